tournament_chooser_pht: RTL

- Parametrised next-generation chooser table for the tournament branch predictor.
- Holds ENTRIES saturating counters of CTR_W bits, indexed by a folded PC hash; selects between component A (bimodal) and component B (global-history).
- Sits in the IF-stage predictor next to the two component predictors. Updated from the branch-resolution path.
- New relative to the previous chooser:
  - width and depth parametrised
  - hardware init sweep after reset
  - stall-hold of the read result, with write forwarding into the held result

---
 rtl/tournament_chooser_pht_if.sv | 41 ++++
 rtl/tournament_chooser_pht.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tournament_chooser_pht_if.sv
// Lookup/update/status bundle for the tournament chooser PHT.
// The perf-counter signals exist only when CHOOSER_PERF_EN is defined.
interface tournament_chooser_pht_if #(
  parameter int CTR_W = 2
) ();
  logic             stall;
  logic             rd_valid;
  logic [31:0]      rd_pc;
  logic [CTR_W-1:0] rd_ctr;
  logic             rd_use_b;
  logic             rd_ctr_valid;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [CTR_W-1:0] upd_ctr;
  logic             upd_a_taken;
  logic             upd_b_taken;
  logic             upd_taken;
  logic             busy;
`ifdef CHOOSER_PERF_EN
  logic [31:0]      perf_upd_cnt;
  logic [31:0]      perf_disagree_cnt;
`endif

  modport master (
    output stall, rd_valid, rd_pc,
    output upd_valid, upd_pc, upd_ctr, upd_a_taken, upd_b_taken, upd_taken,
    input  rd_ctr, rd_use_b, rd_ctr_valid, busy
`ifdef CHOOSER_PERF_EN
    , input perf_upd_cnt, perf_disagree_cnt
`endif
  );

  modport slave (
    input  stall, rd_valid, rd_pc,
    input  upd_valid, upd_pc, upd_ctr, upd_a_taken, upd_b_taken, upd_taken,
    output rd_ctr, rd_use_b, rd_ctr_valid, busy
`ifdef CHOOSER_PERF_EN
    , output perf_upd_cnt, perf_disagree_cnt
`endif
  );
endinterface

// File: rtl/tournament_chooser_pht.sv
// Tournament chooser table: ENTRIES saturating counters picking bimodal (A) vs global (B).
// Hardware init sweep after reset; optional perf counters under CHOOSER_PERF_EN.
//
// state   | meaning
// ST_INIT | sweeping INIT_VAL into every entry, lookups/updates ignored, busy=1
// ST_RUN  | normal lookup and update service
module tournament_chooser_pht #(
  parameter int ENTRIES  = 2048,
  parameter int CTR_W    = 2,
  parameter int INIT_VAL = 1
) (
  input logic                     clk,
  input logic                     reset,
  tournament_chooser_pht_if.slave bus
);
  localparam int               IDX_W    = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT_VAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [CTR_W-1:0] rd_ctr_q, rd_ctr_d;
  logic             rd_ctr_valid_q, rd_ctr_valid_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

  logic [CTR_W-1:0] mem_q [ENTRIES];

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             a_miss;
  logic             b_miss;
  logic [CTR_W-1:0] upd_new;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_data;

  // Only the hashed PC bits matter; the rest are deliberately dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.rd_pc, bus.upd_pc};

  function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
    return pc[2 +: IDX_W] ^ pc[2+IDX_W +: IDX_W];
  endfunction

  assign lookup_idx = pc_idx(bus.rd_pc);
  assign upd_idx    = pc_idx(bus.upd_pc);

  always_comb begin
    a_miss  = bus.upd_a_taken != bus.upd_taken;
    b_miss  = bus.upd_b_taken != bus.upd_taken;
    upd_new = bus.upd_ctr;
    if (a_miss && !b_miss && bus.upd_ctr != CTR_MAX) begin
      upd_new = bus.upd_ctr + CTR_W'(1);
    end else if (!a_miss && b_miss && bus.upd_ctr != '0) begin
      upd_new = bus.upd_ctr - CTR_W'(1);
    end
  end

  // Single write port shared by the init sweep and the update path.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = upd_idx;
    wr_data = upd_new;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_q;
      wr_data = INIT_CTR;
    end else if (bus.upd_valid && (upd_new != bus.upd_ctr)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    rd_ctr_d       = rd_ctr_q;
    rd_ctr_valid_d = rd_ctr_valid_q;
    rd_idx_d       = rd_idx_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          rd_ctr_valid_d = bus.rd_valid;
          if (bus.rd_valid) begin
            rd_idx_d = lookup_idx;
            // A same-edge write to this index beats the stale array word.
            rd_ctr_d = (wr_en && wr_idx == lookup_idx) ? wr_data : mem_q[lookup_idx];
          end
        end else if (rd_ctr_valid_q && wr_en && wr_idx == rd_idx_q) begin
          rd_ctr_d = wr_data;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

`ifdef CHOOSER_PERF_EN
  logic [31:0] perf_upd_q, perf_upd_d;
  logic [31:0] perf_dis_q, perf_dis_d;

  always_comb begin
    perf_upd_d = perf_upd_q;
    perf_dis_d = perf_dis_q;
    if (state_q == ST_RUN && bus.upd_valid) begin
      perf_upd_d = perf_upd_q + 32'd1;
      if (a_miss != b_miss) begin
        perf_dis_d = perf_dis_q + 32'd1;
      end
    end
  end

  assign bus.perf_upd_cnt      = perf_upd_q;
  assign bus.perf_disagree_cnt = perf_dis_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_INIT;
      sweep_q        <= '0;
      rd_ctr_q       <= '0;
      rd_ctr_valid_q <= 1'b0;
      rd_idx_q       <= '0;
`ifdef CHOOSER_PERF_EN
      perf_upd_q     <= '0;
      perf_dis_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      sweep_q        <= sweep_d;
      rd_ctr_q       <= rd_ctr_d;
      rd_ctr_valid_q <= rd_ctr_valid_d;
      rd_idx_q       <= rd_idx_d;
`ifdef CHOOSER_PERF_EN
      perf_upd_q     <= perf_upd_d;
      perf_dis_q     <= perf_dis_d;
`endif
    end
  end

  assign bus.rd_ctr       = rd_ctr_q;
  assign bus.rd_use_b     = rd_ctr_q[CTR_W-1];
  assign bus.rd_ctr_valid = rd_ctr_valid_q;
  assign bus.busy         = (state_q == ST_INIT);
endmodule
